// File: rtl/duc_iq_mixer.sv
// duc_iq_mixer: 4-stage pipelined I/Q up-conversion mixer, I*cos -/+ Q*sin,
// followed by runtime shift with round-half-up and saturation to OW bits.
// Optional macro DUC_IQ_MIXER_OVF_CNT_EN adds a saturating 16-bit ovf_count.
module duc_iq_mixer #(
  parameter int unsigned DW  = 16,
  parameter int unsigned LW  = 16,
  parameter int unsigned OW  = 16,
  parameter int unsigned SHW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic signed [DW-1:0]  I_data,
  input  logic signed [DW-1:0]  Q_data,
  input  logic signed [LW-1:0]  lo_cos,
  input  logic signed [LW-1:0]  lo_sin,
  input  logic                  lsb_sel,
  input  logic                  bypass,
  input  logic [SHW-1:0]        shift_sel,
  output logic                  m_valid,
  output logic signed [OW-1:0]  dac_out,
  output logic                  ovf,
`ifdef DUC_IQ_MIXER_OVF_CNT_EN
  output logic [15:0]           ovf_count,
`endif
  output logic                  ovf_sticky
);

  localparam int unsigned PW = DW + LW;  // product width
  localparam int unsigned SW = PW + 1;   // sum width, cannot overflow
  localparam int unsigned XW = SW + 1;   // headroom for the rounding add

  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // stage 1 registers
  logic                 v1, lsb1, byp1;
  logic signed [DW-1:0] i1, q1;
  logic signed [LW-1:0] c1, s1;
  logic [SHW-1:0]       sh1;

  // stage 2 registers
  logic                 v2, lsb2;
  logic signed [PW-1:0] p_i2, p_q2;
  logic [SHW-1:0]       sh2;

  // stage 3 registers
  logic                 v3;
  logic signed [SW-1:0] sum3;
  logic [SHW-1:0]       sh3;

  // combinational intermediates
  logic signed [PW-1:0] p_i_c, p_q_c;
  logic signed [XW-1:0] ext_c, rnd_c, rounded_c, shifted_c;
  logic signed [OW-1:0] res_c;
  logic                 sat_c;

  // S1: capture valid plus sample-aligned data and controls
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= s_valid;
    end
    i1   <= I_data;
    q1   <= Q_data;
    c1   <= lo_cos;
    s1   <= lo_sin;
    lsb1 <= lsb_sel;
    byp1 <= bypass;
    sh1  <= shift_sel;
  end

  // S2 products; bypass places I at the same binary point as a full-scale LO product
  always_comb begin
    p_i_c = PW'(i1) * PW'(c1);
    p_q_c = PW'(q1) * PW'(s1);
    if (byp1) begin
      p_i_c = PW'(i1) <<< (LW - 1);
      p_q_c = '0;
    end
  end

  // S2: register products
  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
    end
    p_i2 <= p_i_c;
    p_q2 <= p_q_c;
    lsb2 <= lsb1;
    sh2  <= sh1;
  end

  // S3: sideband sum at full precision
  always_ff @(posedge clk) begin
    if (reset) begin
      v3 <= 1'b0;
    end else begin
      v3 <= v2;
    end
    sum3 <= lsb2 ? (SW'(p_i2) + SW'(p_q2)) : (SW'(p_i2) - SW'(p_q2));
    sh3  <= sh2;
  end

  // S4 datapath: round half up, arithmetic shift, clamp
  always_comb begin
    ext_c     = XW'(sum3);
    rnd_c     = '0;
    if (sh3 != '0) begin
      rnd_c = XW'(1) <<< (sh3 - SHW'(1));
    end
    rounded_c = ext_c + rnd_c;
    if (32'(sh3) >= SW) begin
      shifted_c = {XW{sum3[SW-1]}};
    end else begin
      shifted_c = rounded_c >>> sh3;
    end
    sat_c = 1'b0;
    res_c = OW'(shifted_c);
    if (shifted_c > SAT_MAX) begin
      sat_c = 1'b1;
      res_c = OW'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      sat_c = 1'b1;
      res_c = OW'(SAT_MIN);
    end
  end

  // S4: output register; idle cycles present mid-scale and no overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      dac_out    <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      m_valid    <= v3;
      dac_out    <= v3 ? res_c : '0;
      ovf        <= v3 & sat_c;
      ovf_sticky <= ovf_sticky | (v3 & sat_c);
    end
  end

`ifdef DUC_IQ_MIXER_OVF_CNT_EN
  // saturating count of overflowed output samples
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (v3 && sat_c && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_duc_iq_mixer.sv
// tb_duc_iq_mixer: directed vectors with hand-computed results for duc_iq_mixer.
module tb_duc_iq_mixer;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic signed [15:0] I_data, Q_data, lo_cos, lo_sin;
  logic               lsb_sel, bypass;
  logic [4:0]         shift_sel;
  logic               m_valid;
  logic signed [15:0] dac_out;
  logic               ovf, ovf_sticky;
`ifdef DUC_IQ_MIXER_OVF_CNT_EN
  logic [15:0]        ovf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // expectation history: index 0 = sample driven this cycle
  logic   hv [0:3];
  longint hd [0:3];
  logic   ho [0:3];

  duc_iq_mixer dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .I_data    (I_data),
    .Q_data    (Q_data),
    .lo_cos    (lo_cos),
    .lo_sin    (lo_sin),
    .lsb_sel   (lsb_sel),
    .bypass    (bypass),
    .shift_sel (shift_sel),
    .m_valid   (m_valid),
    .dac_out   (dac_out),
    .ovf       (ovf),
`ifdef DUC_IQ_MIXER_OVF_CNT_EN
    .ovf_count (ovf_count),
`endif
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_hist();
    for (int j = 0; j < 4; j++) begin
      hv[j] = 1'b0;
      hd[j] = 0;
      ho[j] = 1'b0;
    end
  endtask

  // drive one cycle of input, then check the sample driven three calls earlier
  task automatic tick(input logic v, input int i, input int q, input int c, input int s,
                      input logic lsb, input logic byp, input int sh,
                      input longint exp_dac, input logic exp_ovf);
    s_valid   = v;
    I_data    = 16'(i);
    Q_data    = 16'(q);
    lo_cos    = 16'(c);
    lo_sin    = 16'(s);
    lsb_sel   = lsb;
    bypass    = byp;
    shift_sel = 5'(sh);
    for (int j = 3; j > 0; j--) begin
      hv[j] = hv[j-1];
      hd[j] = hd[j-1];
      ho[j] = ho[j-1];
    end
    hv[0] = v;
    hd[0] = v ? exp_dac : 0;
    ho[0] = v ? exp_ovf : 1'b0;
    @(posedge clk);
    #1;
    check("m_valid", longint'(m_valid), longint'(hv[3]));
    check("dac_out", longint'(dac_out), hd[3]);
    check("ovf", longint'(ovf), longint'(ho[3]));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_hist();
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_dac_out", longint'(dac_out), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_ovf_sticky", longint'(ovf_sticky), 0);
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    I_data = '0; Q_data = '0; lo_cos = '0; lo_sin = '0;
    lsb_sel = 1'b0; bypass = 1'b0; shift_sel = '0;
    clear_hist();
    @(posedge clk);
    apply_reset();

    // single pulse, 16383.5 rounds up
    tick(1'b1, 16384, 0, 32767, 0, 1'b0, 1'b0, 15, 16384, 1'b0);
    idle(4);

    // sideband select, then per-cycle toggling
    tick(1'b1, 0, 16384, 0, 16384, 1'b0, 1'b0, 14, -16384, 1'b0);
    tick(1'b1, 0, 16384, 0, 16384, 1'b1, 1'b0, 14,  16384, 1'b0);
    tick(1'b1, 0, 16384, 0, 16384, 1'b0, 1'b0, 14, -16384, 1'b0);
    tick(1'b1, 0, 16384, 0, 16384, 1'b1, 1'b0, 14,  16384, 1'b0);
    idle(4);

    // shift boundaries: no rounding, negative tie rounds up, shift 31
    tick(1'b1, 3, 0, 5, 0, 1'b0, 1'b0, 0, 15, 1'b0);
    tick(1'b1, -1, 0, 1, 0, 1'b0, 1'b0, 1, 0, 1'b0);
    tick(1'b1, 1, 0, 1, 0, 1'b0, 1'b0, 1, 1, 1'b0);
    tick(1'b1, -32768, 32767, 32767, 32767, 1'b0, 1'b0, 31, -1, 1'b0);
    idle(4);
    check("sticky_clear", longint'(ovf_sticky), 0);

    // positive saturation, then an in-range sample
    tick(1'b1, -32768, 32767, -32768, 32767, 1'b1, 1'b0, 15, 32767, 1'b1);
    tick(1'b1, 16384, 0, 32767, 0, 1'b0, 1'b0, 15, 16384, 1'b0);
    idle(4);
    check("sticky_set", longint'(ovf_sticky), 1);
    // negative saturation
    tick(1'b1, -32768, 32767, 32767, 32767, 1'b0, 1'b0, 15, -32768, 1'b1);
    idle(4);
    check("sticky_held", longint'(ovf_sticky), 1);

    // bypass
    tick(1'b1, -1234, 999, -5, 77, 1'b0, 1'b1, 15, -1234, 1'b0);
    tick(1'b1, 32767, -3, 123, -456, 1'b1, 1'b1, 15, 32767, 1'b0);
    idle(4);

    // valid gaps 1,1,0,1
    tick(1'b1, 16384, 0, 32767, 0, 1'b0, 1'b0, 15, 16384, 1'b0);
    tick(1'b1, 0, 16384, 0, 16384, 1'b0, 1'b0, 14, -16384, 1'b0);
    tick(1'b0, 1000, 1000, 1000, 1000, 1'b0, 1'b0, 15, 0, 1'b0);
    tick(1'b1, 0, 16384, 0, 16384, 1'b1, 1'b0, 14, 16384, 1'b0);
    idle(4);

    // reset with three samples in flight: all discarded
    tick(1'b1, 16384, 0, 32767, 0, 1'b0, 1'b0, 15, 16384, 1'b0);
    tick(1'b1, 16384, 0, 32767, 0, 1'b0, 1'b0, 15, 16384, 1'b0);
    tick(1'b1, -32768, 32767, -32768, 32767, 1'b1, 1'b0, 15, 32767, 1'b1);
    apply_reset();
    idle(6);

    // first sample after reset release, latency 4
    tick(1'b1, 0, 16384, 0, 16384, 1'b1, 1'b0, 14, 16384, 1'b0);
    idle(4);

`ifdef DUC_IQ_MIXER_OVF_CNT_EN
    check("cnt_reset", longint'(ovf_count), 0);
    s_valid = 1'b1; I_data = -16'sd32768; lo_cos = -16'sd32768;
    Q_data = 16'sd32767; lo_sin = 16'sd32767; lsb_sel = 1'b1; bypass = 1'b0; shift_sel = 5'd15;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    s_valid = 1'b0;
    for (int k = 0; k < 6; k++) @(posedge clk);
    #1;
    check("cnt_sat", longint'(ovf_count), 65535);
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    check("cnt_hold", longint'(ovf_count), 65535);
    apply_reset();
    check("cnt_cleared", longint'(ovf_count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duc_iq_mixer.md
Name: duc_iq_mixer

Overview:
Parametrised, fully pipelined digital up-converter mixer. Each cycle it takes one I/Q baseband sample and one LO cos/sin pair, and forms the real IF sample I·cos ∓ Q·sin. The result gets runtime-selectable scaling, round-half-up and saturation. It sits between the baseband modulator/interpolator and the DAC, fed by an external DDS. It adds over the fixed 16-bit mixer: sideband select, valid tracking, overflow status and a bypass mode.

Parameters:
DW, 16, signed width of I_data/Q_data
LW, 16, signed width of lo_cos/lo_sin
OW, 16, signed width of dac_out
SHW, 5, width of shift_sel

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  I/Q/LO inputs valid this cycle
I_data  in  DW  in-phase sample, signed
Q_data  in  DW  quadrature sample, signed
lo_cos  in  LW  DDS cosine, signed
lo_sin  in  LW  DDS sine, signed
lsb_sel  in  1  0: USB, I·cos − Q·sin; 1: LSB, I·cos + Q·sin
bypass  in  1  1: output = I_data passed through scaling path (LO ignored)
shift_sel  in  SHW  arithmetic right shift applied to full-precision sum
m_valid  out  1  dac_out valid
dac_out  out  OW  real IF sample, signed
ovf  out  1  pulse: this output sample saturated
ovf_sticky  out  1  set on any saturation, cleared only by reset

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: m_valid=0, dac_out=0, ovf=0, ovf_sticky=0; all pipeline valid bits cleared.
- Reset mid-stream: in-flight samples are discarded. The first output after reset release comes 4 cycles after the first s_valid seen with reset low.
- Pipeline, fixed latency 4:
  - S1 registers inputs and controls (lsb_sel, bypass, shift_sel) alongside the data, so control changes are sample-aligned.
  - S2 forms products P_I=I·cos and P_Q=Q·sin, each DW+LW bits.
  - S3 forms sum = P_I − P_Q (USB) or P_I + P_Q (LSB), width DW+LW+1, with no internal overflow possible.
  - S4 performs rounding, shift and saturation.
- Bypass: S2 sets P_I = I sign-extended and left-shifted by LW−1, and P_Q=0. With shift_sel=LW−1, I therefore reaches the output unchanged (OW=DW).
- Rounding: if shift_sel>0, add 2^(shift_sel−1) to the sum, then arithmetic right shift by shift_sel; round half up toward +inf. shift_sel=0 means no rounding. shift_sel ≥ DW+LW+1 yields 0 or −1 by sign.
- Saturation: the shifted value is clamped to [−2^(OW−1), 2^(OW−1)−1]. On clamping, ovf=1 for that sample and ovf_sticky is set.
- Handshake: streaming only, no backpressure. m_valid is s_valid delayed by exactly 4 cycles. Gaps in s_valid produce identical gaps in m_valid.
- When m_valid=0: dac_out=0 and ovf=0. An idle DAC sees mid-scale.
- Back-to-back: full throughput of one sample per clock.

Optional Feature:
- Macro DUC_IQ_MIXER_OVF_CNT_EN.
- Defined: adds output ovf_count (16 bits). It increments on each ovf pulse, saturates at 0xFFFF (no wrap) and is cleared by reset.
- Undefined: port absent and no counter logic. All other behaviour is identical.

Test Plan:
1. Defaults; I=16384, Q=0, cos=32767, sin=0, shift=15, lsb_sel=0, single s_valid pulse -> exactly 4 cycles later m_valid=1 for one cycle, dac_out=16384 (16383.5 rounded up), ovf=0.
2. Sideband: I=0, Q=16384, cos=0, sin=16384, shift=14 -> USB dac_out=−16384; same sample with lsb_sel=1 -> +16384. Toggling lsb_sel each cycle gives alternating signs with no mixed sample.
3. Saturation: I=−32768, cos=−32768, Q=32767, sin=32767, lsb_sel=1, shift=15 -> dac_out=32767, ovf=1 pulse, ovf_sticky=1 and held. A following in-range sample gives ovf=0 with ovf_sticky still 1.
4. Bypass: bypass=1, shift=15, I=−1234, arbitrary Q and LO -> dac_out=−1234. I=32767 -> 32767 with ovf=0.
5. Valid gaps and reset: s_valid pattern 1,1,0,1 -> m_valid 1,1,0,1 after 4 cycles with dac_out=0 in the gap. Reset asserted while 3 samples are in flight -> no m_valid emitted, and outputs are 0 the cycle after reset.
6. With DUC_IQ_MIXER_OVF_CNT_EN: 70000 consecutive saturating samples -> ovf_count=0xFFFF and holds; reset -> 0.
